mux_sel_arbiter_4: RTL and testbench

//   Round-robin arbiter for the 4:1 BUS_WIDTH data mux. It produces the mux's 2-bit select.
//   It also drives a valid/ready handshake towards the consumer of the mux output.

---
 rtl/mux_sel_arbiter_4_pkg.sv | 31 +++
 rtl/mux_sel_arbiter_4_if.sv | 30 +++
 rtl/mux_sel_arbiter_4_rr_pick_4.sv | 32 +++
 rtl/mux_sel_arbiter_4.sv | 117 +++++++++++
 tb/tb_mux_sel_arbiter_4.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mux_sel_arbiter_4_pkg.sv
// Purpose: shared widths, types, FSM encoding and helpers for the 4-way
//          round-robin mux-select arbiter.
// Contents: N_REQ/SEL_W widths, req_t/sel_t types, state_t encoding,
//           sel_to_onehot() and sel_next() helpers.
package mux_sel_arbiter_4_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef logic [N_REQ-1:0] req_t;
    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // One-hot grant vector for a select value
    function automatic req_t sel_to_onehot(input sel_t s);
        req_t v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    // Next requester in round-robin order, wrapping 3 -> 0
    function automatic sel_t sel_next(input sel_t s);
        return s + sel_t'(1);
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_4_if.sv
// Purpose: requester/consumer handshake bundle between the arbiter and its
//          surroundings (requesters, mux_4_1, downstream consumer).
// Signals: req[3:0]   requester i holds a word on mux input i
//          out_ready  downstream accepts the mux output this cycle
//          sel[1:0]   registered mux select
//          grant[3:0] registered one-hot of sel while granted
//          out_valid  combinational mux-output valid
//          ack[3:0]   combinational one-hot accept pulse back to requesters
// Modports: master = arbiter side, slave = requester/consumer side.
interface mux_sel_arbiter_4_if;
    import mux_sel_arbiter_4_pkg::*;

    req_t req;
    logic out_ready;
    sel_t sel;
    req_t grant;
    logic out_valid;
    req_t ack;

    modport master (
        input  req, out_ready,
        output sel, grant, out_valid, ack
    );

    modport slave (
        output req, out_ready,
        input  sel, grant, out_valid, ack
    );

endinterface

// File: rtl/mux_sel_arbiter_4_rr_pick_4.sv
// Purpose: combinational round-robin picker. Finds the first set bit of
//          i_req scanning i_start, i_start+1, ... modulo 4.
// Ports: i_req[3:0]  request vector
//        i_start[1:0] highest-priority position
//        o_found     any request set
//        o_idx[1:0]  winning position (i_start when nothing is found)
module rr_pick_4
    import mux_sel_arbiter_4_pkg::*;
(
    input  req_t i_req,
    input  sel_t i_start,
    output logic o_found,
    output sel_t o_idx
);

    sel_t w_cand;

    // Scan from the lowest priority upward so the highest-priority hit wins last
    always_comb begin
        o_found = 1'b0;
        o_idx   = i_start;
        w_cand  = i_start;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = i_start + sel_t'(k);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter_4.sv
// Purpose: round-robin arbiter producing the select of a 4:1 data mux, with a
//          valid/ready handshake towards the mux-output consumer and bursts of
//          up to MAX_BURST accepted words per grant.
// Ports: clk  single clock, rising edge
//        rst  synchronous active-high reset
//        bus  mux_sel_arbiter_4_if.master (req, out_ready in;
//             sel, grant registered out; out_valid, ack combinational out)
module mux_sel_arbiter_4
    import mux_sel_arbiter_4_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    mux_sel_arbiter_4_if.master        bus
);

    localparam int unsigned       CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t           r_state;
    sel_t             r_sel;
    req_t             r_grant;
    sel_t             r_ptr;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_nxt;
    sel_t             w_sel_nxt;
    req_t             w_grant_nxt;
    sel_t             w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_valid;
    logic             w_xfer;
    logic             w_rearb;
    sel_t             w_pick_start;
    logic             w_pick_found;
    sel_t             w_pick_idx;

    assign w_valid = (r_state == ST_GRANT) && bus.req[r_sel];
    assign w_xfer  = w_valid && bus.out_ready;
    // Grant ends when the burst is used up or the owner has nothing to offer
    assign w_rearb = (r_state == ST_GRANT) &&
                     ((w_xfer && (r_cnt == CNT_LAST)) || !bus.req[r_sel]);

    // IDLE resumes from the stored pointer; rearbitration starts after the owner
    assign w_pick_start = (r_state == ST_GRANT) ? sel_next(r_sel) : r_ptr;

    rr_pick_4 u_pick (
        .i_req   (bus.req),
        .i_start (w_pick_start),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_grant <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and next-register values
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_pick_idx;
                    w_grant_nxt = sel_to_onehot(w_pick_idx);
                    w_cnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                if (w_rearb) begin
                    w_ptr_nxt = sel_next(r_sel);
                    w_cnt_nxt = '0;
                    if (w_pick_found) begin
                        w_sel_nxt   = w_pick_idx;
                        w_grant_nxt = sel_to_onehot(w_pick_idx);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = '0;
                    end
                end else if (w_xfer) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs; reset suppresses any transfer in its cycle
    always_comb begin
        bus.out_valid = w_valid && !rst;
        bus.ack       = r_grant & {N_REQ{w_xfer && !rst}};
    end

    assign bus.sel   = r_sel;
    assign bus.grant = r_grant;

endmodule

// File: tb/tb_mux_sel_arbiter_4.sv
module tb_mux_sel_arbiter_4;
    import mux_sel_arbiter_4_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_sel_arbiter_4_if bus4 ();
    mux_sel_arbiter_4_if bus1 ();

    mux_sel_arbiter_4 #(.MAX_BURST(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    mux_sel_arbiter_4 #(.MAX_BURST(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int   checks = 0;
    int   errors = 0;
    req_t q4[$];
    req_t q1[$];

    logic n_rst;
    req_t n_req4, n_req1;
    logic n_rdy4, n_rdy1;

    // One cycle: apply pending inputs after the falling edge, then the
    // scoreboard consumes every ack the DUTs produce in that cycle.
    task automatic tick();
        req_t e;
        @(negedge clk);
        rst            = n_rst;
        bus4.req       = n_req4;
        bus4.out_ready = n_rdy4;
        bus1.req       = n_req1;
        bus1.out_ready = n_rdy1;
        #1;
        if (bus4.ack !== 4'b0000) begin
            checks++;
            if (q4.size() == 0) begin
                errors++; $display("FAIL sb4_unexpected got=%b exp=none", bus4.ack);
            end else begin
                e = q4.pop_front();
                if (bus4.ack !== e) begin errors++; $display("FAIL sb4_ack got=%b exp=%b", bus4.ack, e); end
            end
        end
        if (bus1.ack !== 4'b0000) begin
            checks++;
            if (q1.size() == 0) begin
                errors++; $display("FAIL sb1_unexpected got=%b exp=none", bus1.ack);
            end else begin
                e = q1.pop_front();
                if (bus1.ack !== e) begin errors++; $display("FAIL sb1_ack got=%b exp=%b", bus1.ack, e); end
            end
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b1; n_req4 = 4'b1111; n_rdy4 = 1'b1; n_req1 = 4'b1111; n_rdy1 = 1'b1;
        tick();
        checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid4 got=%b exp=0", bus4.out_valid); end
        checks++; if (bus4.ack !== 4'b0000) begin errors++; $display("FAIL rst_ack4 got=%b exp=0000", bus4.ack); end
        checks++; if (bus1.ack !== 4'b0000) begin errors++; $display("FAIL rst_ack1 got=%b exp=0000", bus1.ack); end
        tick();
        n_rst = 1'b0; n_req4 = '0; n_rdy4 = 1'b0; n_req1 = '0; n_rdy1 = 1'b0;
        tick();
        checks++; if (bus4.sel !== 2'd0) begin errors++; $display("FAIL rst_sel4 got=%0d exp=0", bus4.sel); end
        checks++; if (bus4.grant !== 4'b0000) begin errors++; $display("FAIL rst_grant4 got=%b exp=0000", bus4.grant); end
        checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid4 got=%b exp=0", bus4.out_valid); end
        checks++; if (bus1.grant !== 4'b0000) begin errors++; $display("FAIL rst_grant1 got=%b exp=0000", bus1.grant); end
    endtask

    // Single requester 2: one cycle latency, then accepted
    task automatic test_single_req();
        n_req4 = 4'b0100; n_rdy4 = 1'b0;
        tick();
        checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL single_latency got=%b exp=0", bus4.out_valid); end
        tick();
        checks++; if (bus4.sel !== 2'd2) begin errors++; $display("FAIL single_sel got=%0d exp=2", bus4.sel); end
        checks++; if (bus4.grant !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", bus4.grant); end
        checks++; if (bus4.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", bus4.out_valid); end
        checks++; if (bus4.ack !== 4'b0000) begin errors++; $display("FAIL single_noack got=%b exp=0000", bus4.ack); end
        n_rdy4 = 1'b1; q4.push_back(4'b0100);
        tick();
        checks++; if (bus4.ack !== 4'b0100) begin errors++; $display("FAIL single_ack got=%b exp=0100", bus4.ack); end
        n_req4 = '0;
        tick();
        checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL single_drop_valid got=%b exp=0", bus4.out_valid); end
        n_rdy4 = 1'b0;
        tick();
        checks++; if (bus4.grant !== 4'b0000) begin errors++; $display("FAIL single_idle_grant got=%b exp=0000", bus4.grant); end
    endtask

    // MAX_BURST=1, all requesting: word-level rotation without bubbles
    task automatic test_rr_burst1();
        sel_t es;
        n_req1 = 4'b1111; n_rdy1 = 1'b1;
        tick();
        checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL rr1_latency got=%b exp=0", bus1.out_valid); end
        for (int i = 0; i < 5; i++) begin
            es = sel_t'(i % 4);
            q1.push_back(sel_to_onehot(es));
            tick();
            checks++; if (bus1.sel !== es) begin errors++; $display("FAIL rr1_sel[%0d] got=%0d exp=%0d", i, bus1.sel, es); end
            checks++; if (bus1.ack !== sel_to_onehot(es)) begin errors++; $display("FAIL rr1_ack[%0d] got=%b exp=%b", i, bus1.ack, sel_to_onehot(es)); end
        end
        n_req1 = '0;
        tick();
        checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL rr1_drop_valid got=%b exp=0", bus1.out_valid); end
        n_rdy1 = 1'b0;
        tick();
        checks++; if (bus1.grant !== 4'b0000) begin errors++; $display("FAIL rr1_idle_grant got=%b exp=0000", bus1.grant); end
    endtask

    // MAX_BURST=4, lone requester 1: regranted to itself with no bubble
    task automatic test_burst_same();
        n_req4 = 4'b0010; n_rdy4 = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            q4.push_back(4'b0010);
            tick();
            checks++; if (bus4.sel !== 2'd1) begin errors++; $display("FAIL same_sel[%0d] got=%0d exp=1", i, bus4.sel); end
            checks++; if (bus4.ack !== 4'b0010) begin errors++; $display("FAIL same_ack[%0d] got=%b exp=0010", i, bus4.ack); end
        end
        n_req4 = '0;
        tick();
        n_rdy4 = 1'b0;
        tick();
        checks++; if (bus4.grant !== 4'b0000) begin errors++; $display("FAIL same_idle_grant got=%b exp=0000", bus4.grant); end
    endtask

    // MAX_BURST=4, requesters 1 and 3 from pointer 2: bursts of four alternate
    task automatic test_burst_rotate();
        sel_t exp_sel[10] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3};
        n_req4 = 4'b1010; n_rdy4 = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            q4.push_back(sel_to_onehot(exp_sel[i]));
            tick();
            checks++; if (bus4.sel !== exp_sel[i]) begin errors++; $display("FAIL rot_sel[%0d] got=%0d exp=%0d", i, bus4.sel, exp_sel[i]); end
        end
        n_req4 = '0;
        tick();
        n_rdy4 = 1'b0;
        tick();
        checks++; if (bus4.grant !== 4'b0000) begin errors++; $display("FAIL rot_idle_grant got=%b exp=0000", bus4.grant); end
    endtask

    // Grant on 3 stalled by ready=0 while req[0] rises; then wrap to 0
    task automatic test_stall();
        n_req4 = 4'b1000; n_rdy4 = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_req4 = (i >= 1) ? 4'b1001 : 4'b1000;
            tick();
            checks++; if (bus4.sel !== 2'd3) begin errors++; $display("FAIL stall_sel[%0d] got=%0d exp=3", i, bus4.sel); end
            checks++; if (bus4.grant !== 4'b1000) begin errors++; $display("FAIL stall_grant[%0d] got=%b exp=1000", i, bus4.grant); end
            checks++; if (bus4.ack !== 4'b0000) begin errors++; $display("FAIL stall_ack[%0d] got=%b exp=0000", i, bus4.ack); end
        end
        n_rdy4 = 1'b1; q4.push_back(4'b1000);
        tick();
        checks++; if (bus4.ack !== 4'b1000) begin errors++; $display("FAIL stall_release got=%b exp=1000", bus4.ack); end
        n_req4 = 4'b0001;
        tick();
        checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL stall_drop_valid got=%b exp=0", bus4.out_valid); end
        q4.push_back(4'b0001);
        tick();
        checks++; if (bus4.sel !== 2'd0) begin errors++; $display("FAIL stall_wrap_sel got=%0d exp=0", bus4.sel); end
        n_req4 = '0;
        tick();
        n_rdy4 = 1'b0;
        tick();
        checks++; if (bus4.grant !== 4'b0000) begin errors++; $display("FAIL stall_idle_grant got=%b exp=0000", bus4.grant); end
    endtask

    // Owner withdraws without a transfer: bubble cycle, then next requester
    task automatic test_withdraw();
        n_req4 = 4'b0110; n_rdy4 = 1'b0;
        tick();
        tick();
        checks++; if (bus4.sel !== 2'd1) begin errors++; $display("FAIL wd_first_sel got=%0d exp=1", bus4.sel); end
        n_req4 = 4'b0100;
        tick();
        checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL wd_valid got=%b exp=0", bus4.out_valid); end
        tick();
        checks++; if (bus4.sel !== 2'd2) begin errors++; $display("FAIL wd_next_sel got=%0d exp=2", bus4.sel); end
        checks++; if (bus4.grant !== 4'b0100) begin errors++; $display("FAIL wd_next_grant got=%b exp=0100", bus4.grant); end
        n_req4 = '0;
        tick();
        tick();
        checks++; if (bus4.grant !== 4'b0000) begin errors++; $display("FAIL wd_idle_grant got=%b exp=0000", bus4.grant); end
    endtask

    // Reset on a would-be transfer cycle: no ack, back to IDLE
    task automatic test_reset_xfer();
        n_req4 = 4'b0001; n_rdy4 = 1'b1;
        tick();
        n_rst = 1'b1;
        tick();
        checks++; if (bus4.ack !== 4'b0000) begin errors++; $display("FAIL rx_ack got=%b exp=0000", bus4.ack); end
        n_rst = 1'b0;
        tick();
        checks++; if (bus4.grant !== 4'b0000) begin errors++; $display("FAIL rx_grant got=%b exp=0000", bus4.grant); end
        checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL rx_idle_valid got=%b exp=0", bus4.out_valid); end
        q4.push_back(4'b0001);
        tick();
        checks++; if (bus4.ack !== 4'b0001) begin errors++; $display("FAIL rx_regrant got=%b exp=0001", bus4.ack); end
        n_req4 = '0; n_rdy4 = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus4.req = '0; bus4.out_ready = 1'b0;
        bus1.req = '0; bus1.out_ready = 1'b0;
        test_reset();
        test_single_req();
        test_rr_burst1();
        test_burst_same();
        test_burst_rotate();
        test_stall();
        test_withdraw();
        test_reset_xfer();
        checks++; if (q4.size() != 0) begin errors++; $display("FAIL sb4_leftover got=%0d exp=0", q4.size()); end
        checks++; if (q1.size() != 0) begin errors++; $display("FAIL sb1_leftover got=%0d exp=0", q1.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
